// File: rtl/hdmi_timing_pkg.sv
// Shared timing constants and helpers for the HDMI video timing generator.
// Holds standard mode timings, sync polarities and the default counter width.
package hdmi_timing_pkg;

  localparam int CW_DEFAULT = 12;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  localparam axis_timing_t H_640X480  = '{active: 640,  fp: 16,  sync: 96, bp: 48};
  localparam axis_timing_t V_640X480  = '{active: 480,  fp: 10,  sync: 2,  bp: 33};
  localparam bit           HS_640X480 = POL_LOW;
  localparam bit           VS_640X480 = POL_LOW;

  localparam axis_timing_t H_1280X720  = '{active: 1280, fp: 110, sync: 40, bp: 220};
  localparam axis_timing_t V_1280X720  = '{active: 720,  fp: 5,   sync: 5,  bp: 20};
  localparam bit           HS_1280X720 = POL_HIGH;
  localparam bit           VS_1280X720 = POL_HIGH;

  // True when value is representable as an unsigned number of the given width.
  function automatic bit fits_width(int value, int width);
    return (value >= 0) && (longint'(value) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// Video timing bundle: pixel-advance enable in, sync/data_en strobes and
// active-pixel coordinates out. master = timing generator, slave = consumer.
interface hdmi_timing_gen_if
  import hdmi_timing_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) ();

    logic          en;
    logic          h_sync;
    logic          v_sync;
    logic          data_en;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output h_sync, v_sync, data_en, x, y, line_start, frame_start
    );

    modport slave (
        output en,
        input  h_sync, v_sync, data_en, x, y, line_start, frame_start
    );

endinterface

// File: rtl/timing_axis_counter.sv
// One axis (horizontal or vertical) of the video raster: a wrapping position
// counter with ACTIVE / FP / SYNC / BP region decode.
module timing_axis_counter
  import hdmi_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0 || CW <= 0) begin : g_zero_param
        $error("timing_axis_counter: every region length and CW must be non-zero");
    end
    if (!fits_width(TOTAL - 1, CW)) begin : g_width_param
        $error("timing_axis_counter: total length %0d does not fit in %0d bits", TOTAL, CW);
    end

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    assign wrap   = (count == LAST);
    assign active = (count < ACTIVE_END);
    assign sync   = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

endmodule

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: h/v raster counters, registered sync/data_en strobes
// and active-pixel coordinates for the renderer and HDMI output stage.
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_640X480.active,
    parameter int H_FP     = H_640X480.fp,
    parameter int H_SYNC   = H_640X480.sync,
    parameter int H_BP     = H_640X480.bp,
    parameter int V_ACTIVE = V_640X480.active,
    parameter int V_FP     = V_640X480.fp,
    parameter int V_SYNC   = V_640X480.sync,
    parameter int V_BP     = V_640X480.bp,
    parameter bit HS_POL   = HS_640X480,
    parameter bit VS_POL   = VS_640X480,
    parameter int CW       = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    hdmi_timing_gen_if.master  vid
);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          h_active;
    logic          v_active;
    logic          h_sync_on;
    logic          v_sync_on;
    logic          visible;
    logic          line_first;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (vid.en),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync_on)
    );

    // The vertical axis advances only on the last pixel of a line, so v_sync
    // edges land exactly on h_cnt == 0.
    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (vid.en && h_wrap),
        .count  (v_cnt),
        .wrap   (),
        .active (v_active),
        .sync   (v_sync_on)
    );

    assign visible    = h_active && v_active;
    assign line_first = visible && (h_cnt == '0);

    // Output stage registers the decode of the pre-increment counters, so the
    // strobes for pixel (0,0) appear one cycle after the first enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.h_sync      <= ~HS_POL;
            vid.v_sync      <= ~VS_POL;
            vid.data_en     <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (vid.en) begin
            vid.h_sync      <= h_sync_on ? HS_POL : ~HS_POL;
            vid.v_sync      <= v_sync_on ? VS_POL : ~VS_POL;
            vid.data_en     <= visible;
            vid.x           <= visible ? h_cnt : '0;
            vid.y           <= visible ? v_cnt : '0;
            vid.line_start  <= line_first;
            vid.frame_start <= line_first && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a 640x480 instance and a tiny positive-polarity
// instance, both compared every cycle against a pixel-index arithmetic model.
module tb_hdmi_timing_gen;
    import hdmi_timing_pkg::*;

    // Instance A: default 640x480@60 timing
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam bit A_HP = 1'b0, A_VP = 1'b0;
    localparam int A_CW = 12;
    // Instance B: tiny raster, active-high syncs
    localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam bit B_HP = 1'b1, B_VP = 1'b1;
    localparam int B_CW = 6;

    typedef struct {
        bit hs;
        bit vs;
        bit de;
        int x;
        int y;
        bit ls;
        bit fs;
    } vid_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done_a = 1'b0;
    bit done_b = 1'b0;

    hdmi_timing_gen_if #(.CW(A_CW)) vid_a ();
    hdmi_timing_gen_if #(.CW(B_CW)) vid_b ();

    hdmi_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(A_HP), .VS_POL(A_VP), .CW(A_CW)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .vid (vid_a)
    );

    hdmi_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(B_HP), .VS_POL(B_VP), .CW(B_CW)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vid (vid_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Outputs are a pure function of p, the number of enabled cycles since reset.
    function automatic vid_t decode(longint p, int ha, int hf, int hs, int hb,
                                    int va, int vf, int vs, int vb, bit hp, bit vp);
        vid_t   r;
        longint ht = longint'(ha + hf + hs + hb);
        longint vt = longint'(va + vf + vs + vb);
        longint h  = p % ht;
        longint v  = (p / ht) % vt;
        r.de = (h < ha) && (v < va);
        r.x  = r.de ? int'(h) : 0;
        r.y  = r.de ? int'(v) : 0;
        r.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        r.vs = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        r.ls = r.de && (h == 0);
        r.fs = r.ls && (v == 0);
        return r;
    endfunction

    function automatic vid_t reset_val(bit hp, bit vp);
        vid_t r;
        r = '{hs: !hp, vs: !vp, de: 1'b0, x: 0, y: 0, ls: 1'b0, fs: 1'b0};
        return r;
    endfunction

    function automatic vid_t exp_a(longint n);
        return (n == 0) ? reset_val(A_HP, A_VP)
                        : decode(n - 1, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP);
    endfunction

    function automatic vid_t exp_b(longint n);
        return (n == 0) ? reset_val(B_HP, B_VP)
                        : decode(n - 1, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_HP, B_VP);
    endfunction

    function automatic logic [36:0] pack(vid_t s);
        logic [15:0] x16;
        logic [15:0] y16;
        x16 = s.x[15:0];
        y16 = s.y[15:0];
        return {s.hs, s.vs, s.de, x16, y16, s.ls, s.fs};
    endfunction

    function automatic vid_t sample_a();
        vid_t r;
        r = '{hs: vid_a.h_sync, vs: vid_a.v_sync, de: vid_a.data_en, x: int'(vid_a.x),
              y: int'(vid_a.y), ls: vid_a.line_start, fs: vid_a.frame_start};
        return r;
    endfunction

    function automatic vid_t sample_b();
        vid_t r;
        r = '{hs: vid_b.h_sync, vs: vid_b.v_sync, de: vid_b.data_en, x: int'(vid_b.x),
              y: int'(vid_b.y), ls: vid_b.line_start, fs: vid_b.frame_start};
        return r;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    longint n_a    = 0;
    longint n_b    = 0;
    bit     live_a = 1'b0;
    bit     live_b = 1'b0;

    always @(posedge clk) begin
        if (rst_a) begin
            n_a    <= 0;
            live_a <= 1'b1;
        end else if (vid_a.en) begin
            n_a <= n_a + 1;
        end
        if (rst_b) begin
            n_b    <= 0;
            live_b <= 1'b1;
        end else if (vid_b.en) begin
            n_b <= n_b + 1;
        end
    end

    // Per-cycle comparison, sampled on the falling edge
    always @(negedge clk) begin
        if (live_a) check("a_cycle", longint'(pack(sample_a())), longint'(pack(exp_a(n_a))));
        if (live_b) check("b_cycle", longint'(pack(sample_b())), longint'(pack(exp_b(n_b))));
    end

    // Hand-computed anchors for the model itself
    initial begin : pin_model
        vid_t want;
        want = '{hs: 1, vs: 1, de: 1, x: 0, y: 1, ls: 1, fs: 0};
        check("model_pixel641", longint'(pack(decode(800, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP))), longint'(pack(want)));
        want = '{hs: 0, vs: 1, de: 0, x: 0, y: 0, ls: 0, fs: 0};
        check("model_hsync_first", longint'(pack(decode(656, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP))), longint'(pack(want)));
        want = '{hs: 1, vs: 0, de: 0, x: 0, y: 0, ls: 0, fs: 0};
        check("model_vsync_line490", longint'(pack(decode(490 * 800, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP))), longint'(pack(want)));
        want = '{hs: 1, vs: 1, de: 1, x: 639, y: 479, ls: 0, fs: 0};
        check("model_last_visible", longint'(pack(decode(479 * 800 + 639, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP))), longint'(pack(want)));
        want = '{hs: 1, vs: 1, de: 1, x: 0, y: 0, ls: 1, fs: 1};
        check("model_frame_wrap", longint'(pack(decode(420000, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP))), longint'(pack(want)));
    end

    // ---------------- instance A stimulus ----------------
    bit de_h [1700];
    bit hs_h [1700];
    bit ls_h [1700];
    int x_h  [1700];
    int y_h  [1700];

    initial begin : stim_a
        int  i;
        int  hs_fall;
        int  hs_low;
        int  ls_next;
        int  r0;
        int  r1;
        int  nrise;
        bit  ls_prev;
        bit  found;
        vid_a.en = 1'b0;
        rst_a    = 1'b1;
        repeat (3) @(negedge clk);
        rst_a    = 1'b0;
        vid_a.en = 1'b1;
        check("a_de_before_en", longint'(vid_a.data_en), 0);
        for (int k = 0; k < 1700; k++) begin
            @(negedge clk);
            de_h[k] = vid_a.data_en;
            hs_h[k] = vid_a.h_sync;
            ls_h[k] = vid_a.line_start;
            x_h[k]  = int'(vid_a.x);
            y_h[k]  = int'(vid_a.y);
        end
        check("a_de_latency", longint'(de_h[0]), 1);
        i = 0;
        while (i < 1700 && de_h[i]) i++;
        check("a_de_high_len", i, 640);
        r0 = i;
        while (i < 1700 && !de_h[i]) i++;
        check("a_de_low_len", i - r0, 160);
        hs_fall = -1;
        for (int k = 0; k < 1700; k++) if (hs_fall < 0 && !hs_h[k]) hs_fall = k;
        check("a_hsync_offset", hs_fall, 656);
        hs_low = 0;
        for (int k = 0; k < 800; k++) if (!hs_h[k]) hs_low++;
        check("a_hsync_width", hs_low, 96);
        ls_next = -1;
        for (int k = 1; k < 1700; k++) if (ls_next < 0 && ls_h[k]) ls_next = k;
        check("a_line_period", ls_next, 800);
        check("a_pixel641_x", x_h[800], 0);
        check("a_pixel641_y", y_h[800], 1);
        check("a_pixel641_ls", longint'(ls_h[800]), 1);

        // en on every other cycle: line period doubles
        ls_prev = vid_a.line_start;
        r0 = -1;
        r1 = -1;
        nrise = 0;
        for (int c = 0; c < 3600; c++) begin
            @(negedge clk);
            if (vid_a.line_start && !ls_prev) begin
                if (nrise == 0) r0 = c;
                else if (nrise == 1) r1 = c;
                nrise++;
            end
            ls_prev  = vid_a.line_start;
            vid_a.en = c[0];
        end
        check("a_half_rate_line_period", r1 - r0, 1600);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            vid_a.en = 1'($urandom_range(0, 1));
        end

        // Reset pulse at h_cnt == 300 with en still high
        vid_a.en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            found = (n_a % 800 == 300) && (n_a >= 800);
        end
        check("a_reach_h300", longint'(found), 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("a_mid_line_reset", longint'(pack(sample_a())), longint'(pack(reset_val(A_HP, A_VP))));
        rst_a    = 1'b0;
        vid_a.en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("a_fs_held_low", longint'(vid_a.frame_start), 0);
        end
        vid_a.en = 1'b1;
        @(negedge clk);
        check("a_fs_after_reset", longint'(vid_a.frame_start), 1);
        check("a_xy_after_reset", longint'({vid_a.x, vid_a.y}), 0);
        repeat (20) @(negedge clk);
        done_a = 1'b1;
    end

    // ---------------- instance B stimulus ----------------
    bit hsb [220];
    bit vsb [220];
    bit deb [220];
    bit fsb [220];
    int xb  [220];
    int yb  [220];

    initial begin : stim_b
        int hs_cnt;
        int vs_cnt;
        int de_cnt;
        int fs_cnt;
        int fs_next;
        int vs_first;
        int r0;
        int r1;
        int nrise;
        bit fs_prev;
        vid_b.en = 1'b0;
        rst_b    = 1'b1;
        repeat (3) @(negedge clk);
        rst_b    = 1'b0;
        vid_b.en = 1'b1;
        for (int k = 0; k < 220; k++) begin
            @(negedge clk);
            hsb[k] = vid_b.h_sync;
            vsb[k] = vid_b.v_sync;
            deb[k] = vid_b.data_en;
            fsb[k] = vid_b.frame_start;
            xb[k]  = int'(vid_b.x);
            yb[k]  = int'(vid_b.y);
        end
        hs_cnt = 0;
        vs_cnt = 0;
        de_cnt = 0;
        fs_cnt = 0;
        vs_first = -1;
        for (int k = 0; k < 105; k++) begin
            hs_cnt += int'(hsb[k]);
            vs_cnt += int'(vsb[k]);
            de_cnt += int'(deb[k]);
            fs_cnt += int'(fsb[k]);
            if (vs_first < 0 && vsb[k]) vs_first = k;
        end
        check("b_hsync_high_cycles", hs_cnt, 21);
        check("b_vsync_high_cycles", vs_cnt, 15);
        check("b_vsync_first", vs_first, 75);
        check("b_de_per_frame", de_cnt, 32);
        check("b_fs_per_frame", fs_cnt, 1);
        check("b_fs_first", longint'(fsb[0]), 1);
        fs_next = -1;
        for (int k = 1; k < 220; k++) if (fs_next < 0 && fsb[k]) fs_next = k;
        check("b_frame_period", fs_next, 105);
        check("b_last_visible_x", xb[52], 7);
        check("b_last_visible_y", yb[52], 3);
        check("b_after_last_visible", longint'(deb[53]), 0);

        // Random enable with occasional resets anywhere in the frame
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            vid_b.en = ($urandom_range(0, 3) != 0);
            rst_b    = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst_b = 1'b0;

        fs_prev = vid_b.frame_start;
        r0 = -1;
        r1 = -1;
        nrise = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (vid_b.frame_start && !fs_prev) begin
                if (nrise == 0) r0 = c;
                else if (nrise == 1) r1 = c;
                nrise++;
            end
            fs_prev  = vid_b.frame_start;
            vid_b.en = c[0];
        end
        check("b_half_rate_frame_period", r1 - r0, 210);
        done_b = 1'b1;
    end

    // ---------------- termination ----------------
    initial begin : main
        for (int t = 0; t < 60000 && !(done_a && done_b); t++) @(negedge clk);
        if (!(done_a && done_b)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: done_a=%0d done_b=%0d required 1/1", done_a, done_b);
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
